// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and entry type for the instruction fetch pipe.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int unsigned c_XLEN   = 32;
    localparam int unsigned c_PC_INC = 4;

    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe_if
// Brief    : Instruction-memory, redirect and decode-side signals of fetch_pipe.
// Revision : 1.0
// ============================================================================
interface fetch_pipe_if
    import fetch_pkg::*;
#(
    parameter int XLEN = c_XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_target,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_target,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two FIFO with synchronous clear, push, pop and count.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_flush;

    assign w_flush = rst || i_clr;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (i_push && !w_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    a_no_overrun: assert property (@(posedge clk) disable iff (w_flush)
        !(i_push && !i_pop && (r_count == CW'(DEPTH))));

    a_no_underrun: assert property (@(posedge clk) disable iff (w_flush)
        !(i_pop && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe
// Brief    : Sequential instruction fetch with redirect and decoupling queue.
// Revision : 1.0
// ============================================================================
module fetch_pipe
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = c_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic    Clk,
    input  wire logic    Rst,
    fetch_pipe_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = 2 * XLEN;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_kill;

    logic [CW-1:0]   w_count;
    logic [FW-1:0]   w_head;
    logic [CW:0]     w_occ;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_req;

    // A redirect hides the head this cycle so nothing stale reaches decode.
    assign w_valid = (w_count != '0) && !bus.redirect_valid && !Rst;
    assign w_pop   = w_valid && bus.inst_ready;
    assign w_occ   = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_req   = !Rst && !bus.redirect_valid && (w_occ < (CW+1)'(DEPTH));
    assign w_push  = r_inflight && !r_kill && !bus.redirect_valid;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_pc;
            end
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_target & ~XLEN'(3);
            end else if (w_req) begin
                r_pc <= r_pc + XLEN'(c_PC_INC);
            end
            // A response returning during the redirect cycle is dropped by the
            // queue clear; only a request still outstanding after it needs killing.
            if (bus.redirect_valid) begin
                r_kill <= w_req;
            end else if (r_inflight) begin
                r_kill <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_clr   (bus.redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_req_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst_pc    = Rst ? '0 : w_head[FW-1:XLEN];
    assign bus.inst_data  = Rst ? '0 : w_head[XLEN-1:0];

    a_no_overflow: assert property (@(posedge Clk) disable iff (Rst)
        (({1'b0, w_count} + (CW+1)'(r_inflight)) <= (CW+1)'(DEPTH)));

    a_aligned: assert property (@(posedge Clk) disable iff (Rst)
        bus.imem_req |-> (bus.imem_addr[1:0] == 2'b00));

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pipe
// Brief    : Directed scoreboard bench for fetch_pipe.
// Revision : 1.0
// ============================================================================
module tb_fetch_pipe;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_pipe_if #(.XLEN(32)) bus  ();
    fetch_pipe_if #(.XLEN(32)) bus2 ();

    fetch_pipe #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    fetch_pipe #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .Clk (clk),
        .Rst (rst),
        .bus (bus2)
    );

    // Memory: data = 1000_0000 + address, one cycle after the request
    always @(posedge clk) begin
        bus.imem_rdata  <= bus.imem_req  ? (32'h1000_0000 + bus.imem_addr)  : 32'hDEAD_BEEF;
        bus2.imem_rdata <= bus2.imem_req ? (32'h1000_0000 + bus2.imem_addr) : 32'hDEAD_BEEF;
    end

    fetch_entry_t exp_q [$];
    fetch_entry_t mon_e;

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, inst: 32'h1000_0000 + pc});
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        rst                 = r;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.inst_ready      = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 32'h0, rdy);
            if (i == 0) begin
                chk1("rst_req", bus.imem_req, 1'b0);
                chk1("rst_valid", bus.inst_valid, 1'b0);
                chk32("rst_data", bus.inst_data, 32'h0);
                chk32("rst_pc", bus.inst_pc, 32'h0);
                chk32("sb_drained", 32'(exp_q.size()), 32'd0);
            end
        end
    endtask

    // Scoreboard monitor: every accepted instruction must match the queue head
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected pc=%h data=%h expected=none", bus.inst_pc, bus.inst_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.inst_pc !== mon_e.pc || bus.inst_data !== mon_e.inst) begin
                    failures++;
                    $display("FAIL sb_order pc=%h data=%h expected pc=%h data=%h",
                             bus.inst_pc, bus.inst_data, mon_e.pc, mon_e.inst);
                end
            end
        end
    end

    logic [31:0] wrap_exp [4];
    int          wrap_k = 0;

    always @(negedge clk) begin
        if (!rst && bus2.inst_valid && bus2.inst_ready && wrap_k < 4) begin
            checks++;
            if (bus2.inst_pc !== wrap_exp[wrap_k] ||
                bus2.inst_data !== (32'h1000_0000 + wrap_exp[wrap_k])) begin
                failures++;
                $display("FAIL wrap_seq idx=%0d pc=%h data=%h expected pc=%h", wrap_k,
                         bus2.inst_pc, bus2.inst_data, wrap_exp[wrap_k]);
            end
            wrap_k++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        bus.redirect_valid   = 1'b0;
        bus.redirect_target  = 32'h0;
        bus.inst_ready       = 1'b0;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_target = 32'h0;
        bus2.inst_ready      = 1'b1;

        // Streaming from reset, one instruction per cycle
        do_reset(2, 1'b1);
        for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            chk1("a_req", bus.imem_req, 1'b1);
            chk32("a_addr", bus.imem_addr, 32'(4 * c));
            if (c == 1) chk1("a_valid_c1", bus.inst_valid, 1'b0);
            if (c == 2) chk1("a_valid_c2", bus.inst_valid, 1'b1);
        end

        // Back-pressure: queue fills, head held, then drains in order
        do_reset(2, 1'b0);
        for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
        for (int c = 0; c < 16; c++) begin
            cyc(1'b0, 1'b0, 32'h0, (c >= 10));
            if (c < 4) begin
                chk1("b_req", bus.imem_req, 1'b1);
                chk32("b_addr", bus.imem_addr, 32'(4 * c));
            end else if (c < 10) begin
                chk1("b_stall_req", bus.imem_req, 1'b0);
            end
            if (c == 4) chk32("b_addr_held", bus.imem_addr, 32'h10);
            if (c == 9) begin
                chk1("b_hold_valid", bus.inst_valid, 1'b1);
                chk32("b_hold_pc", bus.inst_pc, 32'h0);
                chk32("b_hold_data", bus.inst_data, 32'h1000_0000);
            end
            if (c == 10) begin
                chk1("b_resume_req", bus.imem_req, 1'b1);
                chk32("b_resume_addr", bus.imem_addr, 32'h10);
            end
        end

        // Redirect to a misaligned target while a request is in flight
        do_reset(2, 1'b1);
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, (c == 2), 32'h0000_0103, 1'b1);
            if (c == 2) begin
                chk1("c_redir_req", bus.imem_req, 1'b0);
                chk1("c_redir_valid", bus.inst_valid, 1'b0);
            end
            if (c == 3) begin
                chk1("c_tgt_req", bus.imem_req, 1'b1);
                chk32("c_tgt_addr", bus.imem_addr, 32'h100);
                chk1("c_empty", bus.inst_valid, 1'b0);
            end
            if (c == 4) chk1("c_empty2", bus.inst_valid, 1'b0);
            if (c == 5) begin
                chk1("c_tgt_valid", bus.inst_valid, 1'b1);
                chk32("c_tgt_pc", bus.inst_pc, 32'h100);
            end
        end

        // Back-to-back redirects: last target wins
        do_reset(2, 1'b1);
        push_exp(32'h0); push_exp(32'h80); push_exp(32'h84);
        for (int c = 0; c < 9; c++) begin
            cyc(1'b0, (c == 3 || c == 4), (c == 3) ? 32'h40 : 32'h80, 1'b1);
            if (c == 3 || c == 4) chk1("d_redir_req", bus.imem_req, 1'b0);
            if (c == 5) begin
                chk1("d_req", bus.imem_req, 1'b1);
                chk32("d_addr", bus.imem_addr, 32'h80);
            end
        end

        // Reset pulse with three queued entries and one request in flight
        do_reset(2, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk1("e_pre_valid", bus.inst_valid, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("e_rst_valid", bus.inst_valid, 1'b0);
        chk1("e_rst_req", bus.imem_req, 1'b0);
        push_exp(32'h0); push_exp(32'h4);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("e_post_valid", bus.inst_valid, 1'b0);
        chk1("e_post_req", bus.imem_req, 1'b1);
        chk32("e_post_addr", bus.imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("e_stale_dropped", bus.inst_valid, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);

        do_reset(1, 1'b0);
        chk32("wrap_count", 32'(wrap_k), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
